// File: rtl/dspl_pkg.sv
// Shared definitions for the display message scheduler: FSM encoding,
// seven-segment symbol codes and the digit word packing helper.
package dspl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SHOW = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [3:0] SYM_0 = 4'h0;
   localparam logic [3:0] SYM_1 = 4'h1;
   localparam logic [3:0] SYM_2 = 4'h2;
   localparam logic [3:0] SYM_3 = 4'h3;
   localparam logic [3:0] SYM_4 = 4'h4;
   localparam logic [3:0] SYM_5 = 4'h5;
   localparam logic [3:0] SYM_6 = 4'h6;
   localparam logic [3:0] SYM_7 = 4'h7;
   localparam logic [3:0] SYM_8 = 4'h8;
   localparam logic [3:0] SYM_9 = 4'h9;
   localparam logic [3:0] SYM_P = 4'hA;
   localparam logic [3:0] SYM_B = 4'hB;
   localparam logic [3:0] SYM_C = 4'hC;
   localparam logic [3:0] SYM_R = 4'hD;
   localparam logic [3:0] SYM_E = 4'hE;
   localparam logic [3:0] SYM_S = 4'hF;

   localparam logic [1:0] NO_ID = 2'b11;

   function automatic logic [5:0] digit_pack(input logic en, input logic [3:0] sym, input logic dp);
      return {en, sym, dp};
   endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: counts 0..MS_COUNT-1 and flags the last count as a
// one-cycle tick. A clear restarts the millisecond from zero.
module ms_tick_gen #(
   parameter int MS_COUNT = 100000
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam logic [31:0] LAST = 32'(MS_COUNT - 1);

   logic [31:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q + 32'd1;
      if (clear || (cnt_q == LAST)) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = (cnt_q == LAST);

endmodule

// File: rtl/dspl_msg_sched.sv
// Three-requester message scheduler for the 8-digit display: priority grant,
// timed hold with optional blink, requester 0 preemption and default message.
//
// state | meaning
// IDLE  | showing dflt_msg, granting the lowest pending request
// SHOW  | showing a latched message, counting its hold time down
// DONE  | one-cycle completion pulse, message still visible
module dspl_msg_sched
   import dspl_pkg::*;
#(
   parameter int MS_COUNT = 100000,
   parameter int BLINK_MS = 250
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [47:0] dflt_msg,
   input  logic [2:0]  req,
   input  logic [47:0] msg0,
   input  logic [47:0] msg1,
   input  logic [47:0] msg2,
   input  logic [15:0] hold0,
   input  logic [15:0] hold1,
   input  logic [15:0] hold2,
   input  logic [2:0]  blink,
   output logic [2:0]  ack,
   output logic        busy,
   output logic        done,
   output logic [1:0]  done_id,
   output logic [1:0]  active_id,
   output logic [5:0]  d1,
   output logic [5:0]  d2,
   output logic [5:0]  d3,
   output logic [5:0]  d4,
   output logic [5:0]  d5,
   output logic [5:0]  d6,
   output logic [5:0]  d7,
   output logic [5:0]  d8
);

   localparam logic [15:0] BLINK_RELOAD = 16'(BLINK_MS);

   state_t      state_q, state_d;
   logic [47:0] msg_q, msg_d;
   logic [15:0] rem_q, rem_d;
   logic [15:0] bcnt_q, bcnt_d;
   logic        blink_en_q, blink_en_d;
   logic        dark_q, dark_d;
   logic [2:0]  ack_q, ack_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [1:0]  done_id_q, done_id_d;
   logic [1:0]  active_id_q, active_id_d;
   logic [47:0] disp_q, disp_d;

   logic        tick;
   logic        tick_clear;
   logic        grant;
   logic [1:0]  gid;
   logic [47:0] msg_sel;
   logic [15:0] hold_sel;

   ms_tick_gen #(.MS_COUNT(MS_COUNT)) u_tick (
      .clock (clock),
      .reset (reset),
      .clear (tick_clear),
      .tick  (tick)
   );

   always_comb begin
      gid      = 2'd2;
      msg_sel  = msg2;
      hold_sel = hold2;
      if (req[0]) begin
         gid      = 2'd0;
         msg_sel  = msg0;
         hold_sel = hold0;
      end else if (req[1]) begin
         gid      = 2'd1;
         msg_sel  = msg1;
         hold_sel = hold1;
      end
   end

   always_comb begin
      state_d     = state_q;
      msg_d       = msg_q;
      rem_d       = rem_q;
      bcnt_d      = bcnt_q;
      blink_en_d  = blink_en_q;
      dark_d      = dark_q;
      ack_d       = 3'b000;
      done_d      = 1'b0;
      done_id_d   = done_id_q;
      active_id_d = active_id_q;
      tick_clear  = 1'b0;
      grant       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            active_id_d = NO_ID;
            tick_clear  = 1'b1;
            grant       = |req;
         end
         ST_SHOW: begin
            if ((active_id_q != 2'd0) && req[0]) begin
               grant      = 1'b1;
               tick_clear = 1'b1;
            end else if (tick) begin
               if (rem_q == 16'd1) begin
                  state_d   = ST_DONE;
                  done_d    = 1'b1;
                  done_id_d = active_id_q;
                  rem_d     = '0;
               end else if (rem_q != 16'd0) begin
                  rem_d = rem_q - 16'd1;
               end
               if (bcnt_q <= 16'd1) begin
                  bcnt_d = BLINK_RELOAD;
                  dark_d = blink_en_q ? ~dark_q : 1'b0;
               end else begin
                  bcnt_d = bcnt_q - 16'd1;
               end
            end
         end
         ST_DONE: begin
            state_d     = ST_IDLE;
            active_id_d = NO_ID;
         end
         default: begin
            state_d     = ST_IDLE;
            active_id_d = NO_ID;
         end
      endcase

      // Grant and preemption both restart the hold and blink timers from scratch.
      if (grant) begin
         state_d     = ST_SHOW;
         ack_d       = 3'b001 << gid;
         active_id_d = gid;
         msg_d       = msg_sel;
         rem_d       = (hold_sel == 16'd0) ? 16'd1 : hold_sel;
         blink_en_d  = blink[gid];
         dark_d      = 1'b0;
         bcnt_d      = BLINK_RELOAD;
      end

      busy_d = (state_d != ST_IDLE);

      disp_d = dflt_msg;
      if (state_d != ST_IDLE) begin
         for (int i = 0; i < 8; i++) begin
            disp_d[i*6 +: 6] = digit_pack(msg_d[i*6+5] & ~dark_d, msg_d[i*6+1 +: 4], msg_d[i*6]);
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         msg_q       <= '0;
         rem_q       <= '0;
         bcnt_q      <= '0;
         blink_en_q  <= 1'b0;
         dark_q      <= 1'b0;
         ack_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         done_id_q   <= '0;
         active_id_q <= NO_ID;
         disp_q      <= '0;
      end else begin
         state_q     <= state_d;
         msg_q       <= msg_d;
         rem_q       <= rem_d;
         bcnt_q      <= bcnt_d;
         blink_en_q  <= blink_en_d;
         dark_q      <= dark_d;
         ack_q       <= ack_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         done_id_q   <= done_id_d;
         active_id_q <= active_id_d;
         disp_q      <= disp_d;
      end
   end

   assign ack       = ack_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign done_id   = done_id_q;
   assign active_id = active_id_q;
   assign d1        = disp_q[47:42];
   assign d2        = disp_q[41:36];
   assign d3        = disp_q[35:30];
   assign d4        = disp_q[29:24];
   assign d5        = disp_q[23:18];
   assign d6        = disp_q[17:12];
   assign d7        = disp_q[11:6];
   assign d8        = disp_q[5:0];

endmodule

// File: tb/tb_dspl_msg_sched.sv
// Directed bench for dspl_msg_sched with MS_COUNT=4, BLINK_MS=2.
module tb_dspl_msg_sched;

   localparam logic [47:0] EN_MASK = {8{6'b100000}};

   logic        clock = 1'b0;
   logic        reset;
   logic [47:0] dflt_msg, msg0, msg1, msg2;
   logic [2:0]  req, blink;
   logic [15:0] hold0, hold1, hold2;
   logic [2:0]  ack;
   logic        busy, done;
   logic [1:0]  done_id, active_id;
   logic [5:0]  d1, d2, d3, d4, d5, d6, d7, d8;
   logic [47:0] disp_w;

   int n_vec = 0;
   int n_err = 0;
   int cyc;

   assign disp_w = {d1, d2, d3, d4, d5, d6, d7, d8};

   always #5 clock = ~clock;

   dspl_msg_sched #(.MS_COUNT(4), .BLINK_MS(2)) dut (
      .clock(clock), .reset(reset), .dflt_msg(dflt_msg), .req(req),
      .msg0(msg0), .msg1(msg1), .msg2(msg2),
      .hold0(hold0), .hold1(hold1), .hold2(hold2), .blink(blink),
      .ack(ack), .busy(busy), .done(done), .done_id(done_id), .active_id(active_id),
      .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6), .d7(d7), .d8(d8)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Cycles from the current sample point until done is seen, capped at 200.
   task automatic wait_done(output int c);
      c = 0;
      do begin
         @(negedge clock);
         c++;
      end while (!done && c < 200);
   endtask

   function automatic logic [47:0] mk(input logic [31:0] syms, input logic [7:0] dps);
      logic [47:0] r;
      for (int i = 0; i < 8; i++) begin
         r[47-6*i -: 6] = {1'b1, syms[31-4*i -: 4], dps[7-i]};
      end
      return r;
   endfunction

   initial begin
      reset    = 1'b0;
      req      = 3'b000;
      blink    = 3'b000;
      hold0    = 16'd2;
      hold1    = 16'd3;
      hold2    = 16'd3;
      dflt_msg = mk(32'h0123_4567, 8'h00);
      msg0     = mk(32'hEEEE_0000, 8'h01);
      msg1     = mk(32'hAB0C_DE12, 8'h80);
      msg2     = mk(32'h9876_5432, 8'h10);

      repeat (2) @(negedge clock);
      chk("rst_disp", disp_w, 48'h0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_active", active_id, 2'b11);
      chk("rst_ack_done", {ack, done, done_id}, 6'b0);
      reset = 1'b1;
      @(negedge clock);
      chk("idle_dflt", disp_w, dflt_msg);

      dflt_msg = mk(32'h5555_1111, 8'hF0);
      @(negedge clock);
      chk("dflt_follow", disp_w, dflt_msg);

      // single request from requester 1
      req = 3'b010;
      @(negedge clock);
      chk("t2_ack", ack, 3'b010);
      chk("t2_disp", disp_w, msg1);
      chk("t2_active", active_id, 2'd1);
      chk("t2_busy", busy, 1'b1);
      req = 3'b000;
      wait_done(cyc);
      chk("t2_cycles", cyc, 12);
      chk("t2_done_id", done_id, 2'd1);
      chk("t2_done_disp", disp_w, msg1);
      @(negedge clock);
      chk("t2_after_done", done, 1'b0);
      chk("t2_after_disp", disp_w, dflt_msg);
      chk("t2_after_active", active_id, 2'b11);
      chk("t2_after_busy", busy, 1'b0);

      // two pending requests: 1 wins, 2 follows after one idle cycle
      req = 3'b110;
      @(negedge clock);
      chk("t3_ack1", ack, 3'b010);
      req = 3'b100;
      wait_done(cyc);
      chk("t3_cycles1", cyc, 12);
      chk("t3_done_id1", done_id, 2'd1);
      @(negedge clock);
      chk("t3_gap_ack", ack, 3'b000);
      chk("t3_gap_disp", disp_w, dflt_msg);
      @(negedge clock);
      chk("t3_ack2", ack, 3'b100);
      chk("t3_active2", active_id, 2'd2);
      chk("t3_disp2", disp_w, msg2);
      req = 3'b000;
      wait_done(cyc);
      chk("t3_cycles2", cyc, 12);
      chk("t3_done_id2", done_id, 2'd2);
      repeat (2) @(negedge clock);

      // preemption of requester 2 by requester 0 at 2 ms
      hold2 = 16'd10;
      req   = 3'b100;
      @(negedge clock);
      chk("t4_ack2", ack, 3'b100);
      req = 3'b000;
      repeat (8) @(negedge clock);
      chk("t4_no_done", done, 1'b0);
      req = 3'b001;
      @(negedge clock);
      chk("t4_ack0", ack, 3'b001);
      chk("t4_active0", active_id, 2'd0);
      chk("t4_disp0", disp_w, msg0);
      req = 3'b000;
      wait_done(cyc);
      chk("t4_cycles0", cyc, 8);
      chk("t4_done_id0", done_id, 2'd0);
      repeat (2) @(negedge clock);

      // blink on requester 1, 8 ms hold, 2 ms half-period
      blink = 3'b010;
      hold1 = 16'd8;
      req   = 3'b010;
      @(negedge clock);
      chk("t5_ack", ack, 3'b010);
      req = 3'b000;
      for (int k = 0; k < 32; k++) begin
         chk($sformatf("t5_en_%0d", k), disp_w & EN_MASK, (((k / 8) % 2) == 0) ? EN_MASK : 48'h0);
         chk($sformatf("t5_lo_%0d", k), disp_w & ~EN_MASK, msg1 & ~EN_MASK);
         @(negedge clock);
      end
      chk("t5_done", done, 1'b1);
      chk("t5_done_id", done_id, 2'd1);
      blink = 3'b000;
      repeat (2) @(negedge clock);

      // zero hold behaves as 1 ms
      hold0 = 16'd0;
      req   = 3'b001;
      @(negedge clock);
      chk("t6_ack", ack, 3'b001);
      req = 3'b000;
      wait_done(cyc);
      chk("t6_cycles", cyc, 4);
      chk("t6_done_id", done_id, 2'd0);
      repeat (2) @(negedge clock);

      // reset in the middle of a message
      hold2 = 16'd10;
      req   = 3'b100;
      @(negedge clock);
      chk("t1_ack", ack, 3'b100);
      req = 3'b000;
      repeat (5) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      chk("t1_rst_disp", disp_w, 48'h0);
      chk("t1_rst_ack", ack, 3'b000);
      chk("t1_rst_busy", busy, 1'b0);
      chk("t1_rst_active", active_id, 2'b11);
      reset = 1'b1;
      @(negedge clock);
      chk("t1_rel_disp", disp_w, dflt_msg);
      chk("t1_rel_busy", busy, 1'b0);
      repeat (60) begin
         @(negedge clock);
         if (done) chk("t1_stray_done", done, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
